// File: rtl/stage_decode_scoreboard_if.sv
// Decode-stage pipeline bundle: the decoded-instruction input channel, the EX/WB bypass and
// write-back buses, squash, and the registered output channel into EX.
// master = upstream/downstream environment, slave = decode stage.
interface stage_decode_scoreboard_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            dec_valid;
  logic            dec_ready;
  logic [31:0]     dec_instr;
  logic [AW-1:0]   dec_rs0_addr;
  logic [AW-1:0]   dec_rs1_addr;
  logic [AW-1:0]   dec_rd_addr;
  logic            dec_rd_we;
  logic            ex_fwd_en;
  logic [AW-1:0]   ex_fwd_addr;
  logic [XLEN-1:0] ex_fwd_data;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            squash;
  logic            out_ready;
  logic            out_valid;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_rs0_data;
  logic [XLEN-1:0] out_rs1_data;
  logic [AW-1:0]   out_rd_addr;
  logic            out_rd_we;
  logic [XLEN-1:0] fwd_rs0_data;
  logic [XLEN-1:0] fwd_rs1_data;

  modport master (
    output dec_valid, dec_instr, dec_rs0_addr, dec_rs1_addr, dec_rd_addr, dec_rd_we,
    output ex_fwd_en, ex_fwd_addr, ex_fwd_data, wb_en, wb_addr, wb_data, squash, out_ready,
    input  dec_ready, out_valid, out_instr, out_rs0_data, out_rs1_data, out_rd_addr, out_rd_we,
    input  fwd_rs0_data, fwd_rs1_data
  );

  modport slave (
    input  dec_valid, dec_instr, dec_rs0_addr, dec_rs1_addr, dec_rd_addr, dec_rd_we,
    input  ex_fwd_en, ex_fwd_addr, ex_fwd_data, wb_en, wb_addr, wb_data, squash, out_ready,
    output dec_ready, out_valid, out_instr, out_rs0_data, out_rs1_data, out_rd_addr, out_rd_we,
    output fwd_rs0_data, fwd_rs1_data
  );
endinterface

// File: rtl/stage_decode_scoreboard.sv
// Decode / operand-fetch stage: register file, EX/WB operand bypass, per-register pending
// scoreboard (RAW + WAW interlock) and a valid/ready output register into EX.
// Optional feature macro: DECODE_PERF_EN adds saturating stall/issue performance counters.
module stage_decode_scoreboard #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef DECODE_PERF_EN
  output logic [15:0]              perf_stall_cnt,
  output logic [15:0]              perf_issue_cnt,
`endif
  stage_decode_scoreboard_if.slave bus
);
  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [XLEN-1:0]  rf_q [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;

  logic             out_valid_q;
  logic [31:0]      out_instr_q;
  logic [XLEN-1:0]  out_rs0_q, out_rs1_q;
  logic [AW-1:0]    out_rd_addr_q;
  logic             out_rd_we_q;

  logic             rs0_zero, rs1_zero, rd_zero, wb_zero;
  logic             ex_hit0, ex_hit1, wb_hit0, wb_hit1, wb_hit_rd;
  logic [XLEN-1:0]  rs0_val, rs1_val;
  logic             raw0, raw1, waw, hazard;
  logic             dec_ready, issue;

  // Operand select with bypass priority zero > EX > WB > RF, plus hazard detection.
  always_comb begin
    rs0_zero  = (ZERO_REG != 0) && (bus.dec_rs0_addr == '0);
    rs1_zero  = (ZERO_REG != 0) && (bus.dec_rs1_addr == '0);
    rd_zero   = (ZERO_REG != 0) && (bus.dec_rd_addr == '0);
    wb_zero   = (ZERO_REG != 0) && (bus.wb_addr == '0);
    ex_hit0   = bus.ex_fwd_en && (bus.ex_fwd_addr == bus.dec_rs0_addr);
    ex_hit1   = bus.ex_fwd_en && (bus.ex_fwd_addr == bus.dec_rs1_addr);
    wb_hit0   = bus.wb_en && (bus.wb_addr == bus.dec_rs0_addr);
    wb_hit1   = bus.wb_en && (bus.wb_addr == bus.dec_rs1_addr);
    wb_hit_rd = bus.wb_en && (bus.wb_addr == bus.dec_rd_addr);

    if (rs0_zero)     rs0_val = '0;
    else if (ex_hit0) rs0_val = bus.ex_fwd_data;
    else if (wb_hit0) rs0_val = bus.wb_data;
    else              rs0_val = rf_q[bus.dec_rs0_addr];

    if (rs1_zero)     rs1_val = '0;
    else if (ex_hit1) rs1_val = bus.ex_fwd_data;
    else if (wb_hit1) rs1_val = bus.wb_data;
    else              rs1_val = rf_q[bus.dec_rs1_addr];

    // A pending source is fine if its producer is visible on a bypass bus this cycle.
    raw0   = pend_q[bus.dec_rs0_addr] && !ex_hit0 && !wb_hit0;
    raw1   = pend_q[bus.dec_rs1_addr] && !ex_hit1 && !wb_hit1;
    waw    = bus.dec_rd_we && pend_q[bus.dec_rd_addr] && !wb_hit_rd;
    hazard = raw0 || raw1 || waw;

    dec_ready = !bus.squash && !hazard && (!out_valid_q || bus.out_ready);
    issue     = bus.dec_valid && dec_ready;
  end

  // Scoreboard next state: clears first so a same-cycle set of the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (bus.wb_en) pend_d[bus.wb_addr] = 1'b0;
    // The squashed instruction in the output register will never write back.
    if (bus.squash && out_valid_q && out_rd_we_q) pend_d[out_rd_addr_q] = 1'b0;
    if (issue && bus.dec_rd_we && !rd_zero) pend_d[bus.dec_rd_addr] = 1'b1;
  end

  // Scoreboard and register file state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      rf_q   <= '{default: '0};
    end else begin
      pend_q <= pend_d;
      if (bus.wb_en && !wb_zero) rf_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Output pipeline register: squash > issue > drain to bubble > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_rs0_q     <= '0;
      out_rs1_q     <= '0;
      out_rd_addr_q <= '0;
      out_rd_we_q   <= 1'b0;
    end else if (bus.squash) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
    end else if (issue) begin
      out_valid_q   <= 1'b1;
      out_instr_q   <= bus.dec_instr;
      out_rs0_q     <= rs0_val;
      out_rs1_q     <= rs1_val;
      out_rd_addr_q <= bus.dec_rd_addr;
      out_rd_we_q   <= bus.dec_rd_we;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
    end
  end

`ifdef DECODE_PERF_EN
  logic [15:0] stall_cnt_q, issue_cnt_q;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      if (bus.dec_valid && hazard && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (issue && (issue_cnt_q != 16'hFFFF)) issue_cnt_q <= issue_cnt_q + 16'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_issue_cnt = issue_cnt_q;
`endif

  assign bus.dec_ready    = dec_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_instr    = out_instr_q;
  assign bus.out_rs0_data = out_rs0_q;
  assign bus.out_rs1_data = out_rs1_q;
  assign bus.out_rd_addr  = out_rd_addr_q;
  assign bus.out_rd_we    = out_rd_we_q;
  assign bus.fwd_rs0_data = rs0_val;
  assign bus.fwd_rs1_data = rs1_val;
endmodule

// File: tb/tb_stage_decode_scoreboard.sv
// Scoreboard bench for stage_decode_scoreboard: the stimulus process runs a behavioural model
// (register array, pending flags, one-entry output slot) and queues the expected EX-side
// transaction on every issue; an independent monitor compares whatever the DUT presents.
module tb_stage_decode_scoreboard;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stage_decode_scoreboard_if #(.XLEN(XLEN), .AW(AW)) bus ();

`ifdef DECODE_PERF_EN
  logic [15:0] perf_stall_cnt, perf_issue_cnt;
`endif

  stage_decode_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef DECODE_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_issue_cnt (perf_issue_cnt),
`endif
    .bus            (bus)
  );

  typedef struct {
    logic [31:0]     instr;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [AW-1:0]   rd;
    logic            we;
  } txn_t;

  txn_t exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state.
  logic [XLEN-1:0] m_rf [NREGS];
  bit              m_pend [NREGS];
  bit              m_occ;
  logic [AW-1:0]   m_rd;
  bit              m_we;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [XLEN-1:0] m_op(logic [AW-1:0] a);
    if (a == 0) return '0;
    if (bus.ex_fwd_en && bus.ex_fwd_addr == a) return bus.ex_fwd_data;
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    return m_rf[a];
  endfunction

  function automatic bit m_blocked(logic [AW-1:0] a);
    return m_pend[a] && !(bus.ex_fwd_en && bus.ex_fwd_addr == a) && !(bus.wb_en && bus.wb_addr == a);
  endfunction

  // One clock of the model, evaluated on the inputs currently driven.
  task automatic model_cycle();
    bit   haz, rdy, iss;
    txn_t t;
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        m_rf[i]   = '0;
        m_pend[i] = 1'b0;
      end
      m_occ = 1'b0;
      m_rd  = '0;
      m_we  = 1'b0;
      exp_q.delete();
      return;
    end
    haz = m_blocked(bus.dec_rs0_addr) || m_blocked(bus.dec_rs1_addr) ||
          (bus.dec_rd_we && m_pend[bus.dec_rd_addr] && !(bus.wb_en && bus.wb_addr == bus.dec_rd_addr));
    rdy = !bus.squash && !haz && (!m_occ || bus.out_ready);
    chk("dec_ready", 32'(bus.dec_ready), 32'(rdy));
    chk("fwd_rs0_data", bus.fwd_rs0_data, m_op(bus.dec_rs0_addr));
    chk("fwd_rs1_data", bus.fwd_rs1_data, m_op(bus.dec_rs1_addr));
    iss = bus.dec_valid && rdy;
    if (iss) begin
      t.instr = bus.dec_instr;
      t.a     = m_op(bus.dec_rs0_addr);
      t.b     = m_op(bus.dec_rs1_addr);
      t.rd    = bus.dec_rd_addr;
      t.we    = bus.dec_rd_we;
      exp_q.push_back(t);
    end
    if (bus.wb_en) m_pend[bus.wb_addr] = 1'b0;
    if (bus.squash && m_occ && m_we) m_pend[m_rd] = 1'b0;
    if (iss && bus.dec_rd_we && bus.dec_rd_addr != 0) m_pend[bus.dec_rd_addr] = 1'b1;
    if (bus.squash) m_occ = 1'b0;
    else if (iss) begin
      m_occ = 1'b1;
      m_rd  = bus.dec_rd_addr;
      m_we  = bus.dec_rd_we;
    end else if (bus.out_ready) m_occ = 1'b0;
    if (bus.wb_en && bus.wb_addr != 0) m_rf[bus.wb_addr] = bus.wb_data;
  endtask

  // Inputs are driven at posedge+1; model/check at posedge+2; returns at the next posedge+1.
  task automatic step();
    #1;
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dec_valid    = 1'b0;
    bus.dec_instr    = '0;
    bus.dec_rs0_addr = '0;
    bus.dec_rs1_addr = '0;
    bus.dec_rd_addr  = '0;
    bus.dec_rd_we    = 1'b0;
    bus.ex_fwd_en    = 1'b0;
    bus.ex_fwd_addr  = '0;
    bus.ex_fwd_data  = '0;
    bus.wb_en        = 1'b0;
    bus.wb_addr      = '0;
    bus.wb_data      = '0;
    bus.squash       = 1'b0;
    bus.out_ready    = 1'b1;
    rst              = 1'b0;
  endtask

  task automatic dec(input int unsigned rs0, input int unsigned rs1, input int unsigned rd,
                     input bit we);
    bus.dec_valid    = 1'b1;
    bus.dec_instr    = $urandom | 32'h1;
    bus.dec_rs0_addr = AW'(rs0);
    bus.dec_rs1_addr = AW'(rs1);
    bus.dec_rd_addr  = AW'(rd);
    bus.dec_rd_we    = we;
  endtask

  // Monitor: compares the presented output with the head of the expected queue.
  always @(negedge clk) begin
    txn_t t;
    if (!rst) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out_unexpected: got out_valid=1, expected no live instruction (t=%0t)",
                   $time);
        end else begin
          t = exp_q[0];
          chk("out_instr", bus.out_instr, t.instr);
          chk("out_rs0_data", bus.out_rs0_data, t.a);
          chk("out_rs1_data", bus.out_rs1_data, t.b);
          chk("out_rd_addr", 32'(bus.out_rd_addr), 32'(t.rd));
          chk("out_rd_we", 32'(bus.out_rd_we), 32'(t.we));
          if (bus.squash || bus.out_ready) t = exp_q.pop_front();
        end
      end else begin
        chk("out_instr_nop", bus.out_instr, 32'h0);
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    idle();
    // Reset state of the output register.
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_rs0", bus.out_rs0_data, 32'h0);
    chk("rst_out_rs1", bus.out_rs1_data, 32'h0);
    chk("rst_out_rd", 32'(bus.out_rd_addr), 32'h0);
    chk("rst_out_we", 32'(bus.out_rd_we), 32'h0);

    // 1: write-back then read through the register file.
    bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h55;
    step();
    idle(); dec(3, 0, 1, 1'b0);
    step();
    idle(); step();

    // 2: RAW stall on rd=5, released by the EX bypass.
    dec(0, 0, 5, 1'b1);
    step();
    idle(); dec(5, 0, 2, 1'b0);
    step();
    step();
    bus.ex_fwd_en = 1'b1; bus.ex_fwd_addr = 5'd5; bus.ex_fwd_data = 32'hAB;
    step();
    idle(); step();

    // 3: EX bypass beats WB bypass on the same register.
    bus.ex_fwd_en = 1'b1; bus.ex_fwd_addr = 5'd7; bus.ex_fwd_data = 32'h1;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h2;
    bus.dec_rs1_addr = 5'd7;
    step();
    idle(); step();

    // 4: squash kills the output instruction and its pending bit.
    dec(0, 0, 9, 1'b1); bus.out_ready = 1'b0;
    step();
    dec(0, 0, 4, 1'b0); bus.out_ready = 1'b0; bus.squash = 1'b1;
    step();
    idle(); dec(9, 0, 9, 1'b1);
    step();
    idle(); bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h99;
    step();

    // 5: downstream stall holds the output, then drains.
    idle(); dec(0, 0, 0, 1'b0); bus.out_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      dec(1, 3, 6, 1'b0); bus.out_ready = 1'b0;
      step();
    end
    dec(1, 3, 6, 1'b0);
    step();
    idle(); step();

    // 6: register 0 is hardwired and never pending.
    bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFF;
    step();
    idle(); dec(0, 0, 0, 1'b1);
    step();
    dec(0, 0, 0, 1'b1);
    step();
    idle(); step();

    // Randomised traffic, including occasional mid-stall resets.
    for (int n = 0; n < 3000; n++) begin
      bus.dec_valid    = ($urandom_range(3) != 0);
      bus.dec_instr    = $urandom;
      bus.dec_rs0_addr = AW'($urandom_range(7));
      bus.dec_rs1_addr = AW'($urandom_range(7));
      bus.dec_rd_addr  = AW'($urandom_range(7));
      bus.dec_rd_we    = 1'($urandom_range(1));
      bus.ex_fwd_en    = ($urandom_range(2) == 0);
      bus.ex_fwd_addr  = AW'($urandom_range(7));
      bus.ex_fwd_data  = $urandom;
      bus.wb_en        = ($urandom_range(2) == 0);
      bus.wb_addr      = AW'($urandom_range(7));
      bus.wb_data      = $urandom;
      bus.squash       = ($urandom_range(15) == 0);
      bus.out_ready    = ($urandom_range(3) != 0);
      rst              = ($urandom_range(199) == 0);
      step();
    end

    idle();
    for (int i = 0; i < 4; i++) step();
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
